// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
//   Drives an external up/down counter through n_sweeps full lo->hi->lo
//   sweeps. A run is requested with start in IDLE, limits are latched on
//   acceptance, the counter is loaded with lo, then enabled upward until it
//   reads hi (one-cycle dwell), then downward until it reads lo (dwell),
//   and so on until the requested number of sweeps is complete.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      run request (IDLE only) / terminate active run
//   lo, hi, n_sweeps  sweep limits and sweep count, latched on start
//   count             counter value fed back from the controlled counter
//   cnt_en/mode/load  counter controls (mode 0 = up, 1 = down)
//   cnt_load_val      value loaded into the counter (latched lo)
//   busy, done, err   run in progress / completion pulse / error pulse
//   sweep_cnt         completed sweeps in the current or last run
//
// All outputs are registered. Because cnt_en is a register, its next value
// is computed from the counter value expected after the coming edge (the
// counter loads with priority, otherwise steps when enabled), so the enable
// drops in exactly the cycle the counter shows the turnaround limit.
module updown_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int SW_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [SW_W-1:0]  n_sweeps,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_mode,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW_W-1:0]  sweep_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] lo_q, hi_q, lo_nx, hi_nx;
  logic [SW_W-1:0]  n_q, n_nx, sweep_nx;
  logic             err_nx, en_nx, oor;
  logic [WIDTH-1:0] cnt_pred;

  // lo_q is held from acceptance to the next start, so it doubles as the
  // registered load value.
  assign cnt_load_val = lo_q;

  always_comb begin
    state_nx = state;
    lo_nx    = lo_q;
    hi_nx    = hi_q;
    n_nx     = n_q;
    sweep_nx = sweep_cnt;
    err_nx   = 1'b0;
    oor      = (count < lo_q) || (count > hi_q);

    case (state)
      IDLE: begin
        if (start) begin
          if ((lo < hi) && (n_sweeps != '0)) begin
            lo_nx    = lo;
            hi_nx    = hi;
            n_nx     = n_sweeps;
            sweep_nx = '0;
            state_nx = LOAD;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      LOAD: state_nx = UP;
      UP: begin
        if (oor) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (count == hi_q) begin
          state_nx = DOWN;
        end
      end
      DOWN: begin
        if (oor) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (count == lo_q) begin
          // saturating: never counts past the requested number
          if (sweep_cnt != n_q) sweep_nx = sweep_cnt + 1'b1;
          state_nx = (sweep_nx == n_q) ? DONE : UP;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // abort overrides every other transition and suppresses err/increment
    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
      err_nx   = 1'b0;
      sweep_nx = sweep_cnt;
    end

    // counter value expected after this edge, per the load-over-enable rule
    if (cnt_load)    cnt_pred = cnt_load_val;
    else if (cnt_en) cnt_pred = cnt_mode ? count - 1'b1 : count + 1'b1;
    else             cnt_pred = count;

    en_nx = 1'b0;
    case (state_nx)
      UP:      en_nx = (cnt_pred != hi_nx);
      DOWN:    en_nx = (cnt_pred != lo_nx);
      default: en_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      n_q       <= '0;
      sweep_cnt <= '0;
      cnt_en    <= 1'b0;
      cnt_mode  <= 1'b0;
      cnt_load  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      lo_q      <= lo_nx;
      hi_q      <= hi_nx;
      n_q       <= n_nx;
      sweep_cnt <= sweep_nx;
      cnt_en    <= en_nx;
      cnt_mode  <= (state_nx == DOWN);
      cnt_load  <= (state_nx == LOAD);
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
      err       <= err_nx;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Testbench for updown_sweep_ctrl. A behavioural counter closes the loop on
// count; a run planner expands each accepted run into the per-cycle output
// trace it must produce (load, then per sweep lo..hi up and hi..lo down with
// the enable low at each limit, then done), and a compare process checks the
// DUT against that trace, or against idle values, on every cycle.
module tb_updown_sweep_ctrl;

  logic       clk, rst_n, start, abort;
  logic [3:0] lo_i, hi_i, n_i, count;
  logic       cnt_en, cnt_mode, cnt_load, busy, done, err;
  logic [3:0] cnt_load_val, sweep_cnt;

  updown_sweep_ctrl #(.WIDTH(4), .SW_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .lo(lo_i), .hi(hi_i), .n_sweeps(n_i), .count(count),
    .cnt_en(cnt_en), .cnt_mode(cnt_mode), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .busy(busy), .done(done), .err(err),
    .sweep_cnt(sweep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // controlled counter: load has priority over enable; optional override
  logic [3:0] cnt_r, force_val;
  bit         force_en;
  always @(posedge clk or negedge rst_n)
    if (!rst_n)        cnt_r <= 4'd0;
    else if (cnt_load) cnt_r <= cnt_load_val;
    else if (cnt_en)   cnt_r <= cnt_mode ? cnt_r - 4'd1 : cnt_r + 4'd1;
  assign count = force_en ? force_val : cnt_r;

  typedef struct {
    int cyc; bit skip; bit busy; bit en; bit mchk; bit mode; bit load;
    int lval; bit done; bit err; int sweep; bit cchk; int cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_sweep = 0;
  int   n_chk = 0, n_fail = 0;
  bit   in_reset = 1'b1;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(int c, bit b, bit en, bit mchk, bit mode, bit ld, int lval,
                      bit dn, bit er, int sw, bit cchk, int cv, bit skip);
    exp_t e;
    e.cyc = c; e.busy = b; e.en = en; e.mchk = mchk; e.mode = mode; e.load = ld;
    e.lval = lval; e.done = dn; e.err = er; e.sweep = sw; e.cchk = cchk;
    e.cnt = cv; e.skip = skip;
    q.push_back(e);
  endtask

  // expand an accepted run into its cycle-by-cycle expected outputs
  task automatic push_run(int l, int h, int n, int base);
    int c;
    c = base;
    push(c, 1, 0, 0, 0, 1, l, 0, 0, 0, 0, 0, 0); c++;
    for (int s = 0; s < n; s++) begin
      for (int v = l; v <= h; v++) begin
        push(c, 1, v != h, 1, 0, 0, 0, 0, 0, s, 1, v, 0); c++;
      end
      for (int v = h; v >= l; v--) begin
        push(c, 1, v != l, 1, 1, 0, 0, 0, 0, s, 1, v, 0); c++;
      end
    end
    push(c, 1, 0, 0, 0, 0, 0, 1, 0, n, 1, l, 0);
  endtask

  // compare process
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          if (!e.skip) begin
            chk("busy", busy, e.busy);
            chk("cnt_en", cnt_en, e.en);
            chk("cnt_load", cnt_load, e.load);
            if (e.load) chk("load_val", cnt_load_val, e.lval);
            if (e.mchk) chk("cnt_mode", cnt_mode, e.mode);
            chk("done", done, e.done);
            chk("err", err, e.err);
            chk("sweep_cnt", sweep_cnt, e.sweep);
            if (e.cchk) chk("count", count, e.cnt);
            last_sweep = e.sweep;
          end
        end else begin
          chk("idle_busy", busy, 0);
          chk("idle_en", cnt_en, 0);
          chk("idle_load", cnt_load, 0);
          chk("idle_done", done, 0);
          chk("idle_err", err, 0);
          chk("idle_sweep", sweep_cnt, last_sweep);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(int l, int h, int nn);
    lo_i = 4'(l); hi_i = 4'(h); n_i = 4'(nn); start = 1'b1;
    if (l < h && nn != 0) push_run(l, h, nn, cyc + 1);
    else push(cyc + 1, 0, 0, 0, 0, 0, 0, 0, 1, last_sweep, 0, 0, 0);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() > 0 && g < 2000) begin tick(); g++; end
    chk("drain_timeout", q.size(), 0);
    q.delete();
    tick();
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_en"}, cnt_en, 0);      chk({tag, "_mode"}, cnt_mode, 0);
    chk({tag, "_load"}, cnt_load, 0);  chk({tag, "_lval"}, cnt_load_val, 0);
    chk({tag, "_busy"}, busy, 0);      chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);        chk({tag, "_sweep"}, sweep_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [8];
    int k, l, h, nn, r, ab;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; force_en = 1'b0; force_val = 4'd0;
    lo_i = 4'd0; hi_i = 4'd0; n_i = 4'd0;
    #3 reset_checks("rst");
    @(negedge clk); rst_n = 1'b1;
    tick(); in_reset = 1'b0;
    tick();

    // basic sweep lo=2 hi=5 n=1, with hand-computed timing
    seq[0] = 4'd2; seq[1] = 4'd3; seq[2] = 4'd4; seq[3] = 4'd5;
    seq[4] = 4'd5; seq[5] = 4'd4; seq[6] = 4'd3; seq[7] = 4'd2;
    do_start(2, 5, 1);
    chk("basic_load", cnt_load, 1);
    chk("basic_lval", cnt_load_val, 2);
    chk("basic_load_en", cnt_en, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("basic_seq", count, seq[i]);
      if (i == 0) chk("basic_first_en", cnt_en, 1);
    end
    tick();
    chk("basic_done", done, 1);
    chk("basic_done_sweep", sweep_cnt, 1);
    tick();
    chk("basic_busy_fall", busy, 0);
    drain();

    // rejected starts
    do_start(7, 7, 3);
    chk("rej1_err", err, 1); chk("rej1_busy", busy, 0); chk("rej1_load", cnt_load, 0);
    tick(); chk("rej1_err_pulse", err, 0);
    do_start(3, 9, 0);
    chk("rej2_err", err, 1); chk("rej2_busy", busy, 0); chk("rej2_load", cnt_load, 0);
    drain();

    // full range, three sweeps
    do_start(0, 15, 3);
    drain();
    chk("full_sweep", sweep_cnt, 3);

    // abort during DOWN of the second sweep (lo=3 hi=6 n=3, L=4)
    do_start(3, 6, 3);
    k = cyc - 1;
    while (cyc < k + 15) tick();
    abort = 1'b1;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    tick(); abort = 1'b0;
    chk("abort_busy", busy, 0); chk("abort_en", cnt_en, 0);
    chk("abort_sweep", sweep_cnt, 1); chk("abort_done", done, 0);
    drain();

    // out-of-range count during UP (lo=2 hi=5)
    do_start(2, 5, 1);
    tick(); tick();
    force_val = 4'd9; force_en = 1'b1;
    while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
    push(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    push(cyc + 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick(); force_en = 1'b0;
    chk("oor_err", err, 1); chk("oor_busy", busy, 0); chk("oor_en", cnt_en, 0);
    tick(); chk("oor_err_pulse", err, 0);
    drain();

    // asynchronous reset in the middle of UP, then a fresh run
    do_start(2, 9, 2);
    tick(); tick(); tick();
    #2 rst_n = 1'b0; in_reset = 1'b1;
    #1 reset_checks("midrst");
    q.delete(); last_sweep = 0;
    @(negedge clk); rst_n = 1'b1;
    tick(); in_reset = 1'b0;
    do_start(1, 3, 1);
    drain();
    chk("post_rst_sweep", sweep_cnt, 1);

    // randomized runs with junk inputs, ignored starts and random aborts
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 3);
      for (int j = 0; j < r; j++) tick();
      if ($urandom_range(0, 3) != 0) begin
        l = $urandom_range(0, 14); h = $urandom_range(l + 1, 15); nn = $urandom_range(1, 3);
      end else begin
        l = $urandom_range(0, 15); h = $urandom_range(0, 15); nn = $urandom_range(0, 3);
      end
      do_start(l, h, nn);
      if (l < h && nn != 0) begin
        r  = 2 + 2 * (h - l + 1) * nn;
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, r)) : 0;
        for (int j = 1; j < ((ab != 0) ? ab : r); j++) begin
          start = 1'($urandom_range(0, 1));
          lo_i = 4'($urandom_range(0, 15)); hi_i = 4'($urandom_range(0, 15));
          n_i = 4'($urandom_range(0, 15));
          tick();
        end
        start = 1'b0;
        if (ab != 0) begin
          abort = 1'b1;
          while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
          tick(); abort = 1'b0;
        end
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
